// File: rtl/press_capture.sv
// press_capture: synchronises and debounces k1/k2 and captures each press as one bit (k1 = 1, k2 = 0).
// The bit is delivered over valid/ack and shifted into the press history. Define PRESS_CAPTURE_STATS_EN for press/drop counters.
module press_capture #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HIST_LEN        = 20,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                k1,
    input  logic                k2,
    input  logic                ack,
    output logic                press_valid,
    output logic                press_bit,
    output logic [HIST_LEN-1:0] history,
    output logic [4:0]          hist_fill,
    output logic                conflict,
    output logic [15:0]         press_count,
    output logic [15:0]         drop_count
);

    localparam int                CNT_W        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]        FILL_MAX     = 5'(HIST_LEN);
    localparam logic              RAW_RELEASED = ACTIVE_LOW;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    // Index 0 is k1, index 1 is k2 throughout.
    logic [1:0]       raw;
    logic [1:0]       sync_meta;
    logic [1:0]       sync_out;
    logic [1:0]       level;
    logic [CNT_W-1:0] deb_cnt [2];
    logic [1:0]       deb_level;
    logic [1:0]       press_evt;
    logic [1:0]       state;

    assign raw   = {k2, k1};
    assign level = ACTIVE_LOW ? ~sync_out : sync_out;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_meta <= {2{RAW_RELEASED}};
            sync_out  <= {2{RAW_RELEASED}};
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    // The press event is registered on the same edge the debounced level rises.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
            deb_level <= 2'b00;
            press_evt <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press_evt[i] <= 1'b0;
                if (level[i] == deb_level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    deb_level[i] <= level[i];
                    deb_cnt[i]   <= '0;
                    press_evt[i] <= level[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            press_valid <= 1'b0;
            press_bit   <= 1'b0;
            history     <= '0;
            hist_fill   <= 5'd0;
            conflict    <= 1'b0;
        end else begin
            conflict <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_evt == 2'b11) begin
                        conflict <= 1'b1;
                        state    <= HOLD;
                    end else if (press_evt != 2'b00) begin
                        press_bit   <= press_evt[0];
                        press_valid <= 1'b1;
                        state       <= PENDING;
                    end
                end
                PENDING: begin
                    if (ack) begin
                        press_valid <= 1'b0;
                        history     <= {history[HIST_LEN-2:0], press_bit};
                        if (hist_fill != FILL_MAX) begin
                            hist_fill <= hist_fill + 5'd1;
                        end
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    // A button still held must be released before it can trigger again.
                    if (deb_level == 2'b00) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PRESS_CAPTURE_STATS_EN
    logic        accept;
    logic [1:0]  drop_inc;
    logic [15:0] press_cnt_r;
    logic [15:0] drop_cnt_r;

    // Outside IDLE every event is ignored; in IDLE only a simultaneous pair is dropped.
    always_comb begin
        accept   = (state == PENDING) && ack;
        drop_inc = 2'd0;
        case (state)
            IDLE: begin
                if (press_evt == 2'b11) begin
                    drop_inc = 2'd2;
                end
            end
            default: begin
                drop_inc = {1'b0, press_evt[0]} + {1'b0, press_evt[1]};
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            press_cnt_r <= 16'd0;
            drop_cnt_r  <= 16'd0;
        end else begin
            if (accept) begin
                press_cnt_r <= press_cnt_r + 16'd1;
            end
            drop_cnt_r <= drop_cnt_r + 16'(drop_inc);
        end
    end

    assign press_count = press_cnt_r;
    assign drop_count  = drop_cnt_r;
`else
    assign press_count = 16'd0;
    assign drop_count  = 16'd0;
`endif

endmodule

// File: tb/tb_press_capture.sv
// Scoreboard bench for press_capture (DEBOUNCE_CYCLES = 4, ACTIVE_LOW = 1): stimulus queues
// the expected presses, a monitor retires them as press_valid rises and falls.
`timescale 1ns/1ps
module tb_press_capture;

    localparam int HIST_LEN = 20;
    localparam int LATENCY  = 7;
`ifdef PRESS_CAPTURE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                CLOCK_50 = 1'b0;
    logic                reset;
    logic                k1;
    logic                k2;
    logic                ack;
    logic                press_valid;
    logic                press_bit;
    logic [HIST_LEN-1:0] history;
    logic [4:0]          hist_fill;
    logic                conflict;
    logic [15:0]         press_count;
    logic [15:0]         drop_count;

    press_capture #(
        .DEBOUNCE_CYCLES(4),
        .HIST_LEN       (HIST_LEN),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .k1         (k1),
        .k2         (k2),
        .ack        (ack),
        .press_valid(press_valid),
        .press_bit  (press_bit),
        .history    (history),
        .hist_fill  (hist_fill),
        .conflict   (conflict),
        .press_count(press_count),
        .drop_count (drop_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic                pbit;
        int                  rise_cycle;
        logic [HIST_LEN-1:0] hist;
        logic [4:0]          fill;
    } exp_t;

    exp_t                exp_q[$];
    exp_t                cur;
    bit                  have_cur      = 1'b0;
    bit                  prev_valid    = 1'b0;
    bit                  ack_en        = 1'b0;
    bit                  ack_force     = 1'b0;
    int                  checks        = 0;
    int                  errors        = 0;
    int                  cycle         = 0;
    int                  valid_rises   = 0;
    int                  conflict_seen = 0;
    logic [HIST_LEN-1:0] model_hist    = '0;
    logic [4:0]          model_fill    = 5'd0;
    logic                bounce_level;

    always @(posedge CLOCK_50) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives both raw buttons (0 = pressed) and holds them for n cycles; called on a negedge.
    task automatic applyStimulus(input logic k1_val, input logic k2_val, input int n);
        k1 = k1_val;
        k2 = k2_val;
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic pressButton(input bit is_k1);
        exp_t e;
        model_hist = {model_hist[HIST_LEN-2:0], is_k1};
        if (model_fill < 5'(HIST_LEN)) model_fill = model_fill + 5'd1;
        e.pbit       = is_k1;
        e.rise_cycle = cycle + LATENCY;
        e.hist       = model_hist;
        e.fill       = model_fill;
        exp_q.push_back(e);
        applyStimulus(is_k1 ? 1'b0 : 1'b1, is_k1 ? 1'b1 : 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 12);
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset      = 1'b0;
        model_hist = '0;
        model_fill = 5'd0;
    endtask

    initial begin
        ack = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            ack = ack_force || (press_valid && ack_en);
        end
    end

    // Monitor: pops on each press_valid rise, checks stability, then the history on its fall.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (conflict) conflict_seen++;
            if (press_valid && !prev_valid) begin
                valid_rises++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_valid: press_valid rose at cycle %0d with press_bit %0b, no press expected", cycle, press_bit);
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    checkOutput("press_bit_on_rise", press_bit, cur.pbit);
                    checkOutput("valid_latency", cycle, cur.rise_cycle);
                end
            end else if (press_valid && have_cur) begin
                checkOutput("press_bit_stable", press_bit, cur.pbit);
            end
            if (!press_valid && prev_valid && have_cur) begin
                checkOutput("history_after", history, cur.hist);
                checkOutput("fill_after", hist_fill, cur.fill);
                have_cur = 1'b0;
            end
            prev_valid = press_valid;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        k1    = 1'b1;
        k2    = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 20);
        $display("[TB] reset and idle");
        checkOutput("reset_valid", press_valid, 0);
        checkOutput("reset_bit", press_bit, 0);
        checkOutput("reset_history", history, 0);
        checkOutput("reset_fill", hist_fill, 0);
        checkOutput("reset_conflict", conflict, 0);
        checkOutput("reset_press_count", press_count, 0);
        checkOutput("reset_drop_count", drop_count, 0);

        $display("[TB] single k1 press");
        ack_en = 1'b1;
        pressButton(1'b1);
        checkOutput("single_history", history, 20'h00001);
        checkOutput("single_fill", hist_fill, 1);
        checkOutput("single_rises", valid_rises, 1);

        $display("[TB] k2 bounce with stray ack");
        ack_force    = 1'b1;
        bounce_level = 1'b1;
        for (int i = 0; i < 15; i++) begin
            bounce_level = ~bounce_level;
            applyStimulus(1'b1, bounce_level, 2);
        end
        applyStimulus(1'b1, 1'b1, 10);
        ack_force = 1'b0;
        applyStimulus(1'b1, 1'b1, 2);
        checkOutput("bounce_rises", valid_rises, 1);
        checkOutput("bounce_history", history, 20'h00001);
        checkOutput("bounce_fill", hist_fill, 1);

        $display("[TB] 22 alternating presses");
        for (int i = 0; i < 22; i++) begin
            pressButton(i % 2 == 0);
        end
        checkOutput("sat_history", history, 20'hAAAAA);
        checkOutput("sat_fill", hist_fill, 20);
        checkOutput("sat_rises", valid_rises, 23);
        checkOutput("sat_press_count", press_count, STATS ? 23 : 0);
        checkOutput("sat_drop_count", drop_count, 0);

        $display("[TB] simultaneous press");
        doReset();
        conflict_seen = 0;
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("conflict_pulses", conflict_seen, 1);
        checkOutput("conflict_valid", press_valid, 0);
        checkOutput("conflict_rises", valid_rises, 23);
        checkOutput("conflict_drop_count", drop_count, STATS ? 2 : 0);
        applyStimulus(1'b1, 1'b1, 12);
        pressButton(1'b0);
        checkOutput("after_conflict_history", history, 0);
        checkOutput("after_conflict_fill", hist_fill, 1);
        checkOutput("after_conflict_press_count", press_count, STATS ? 1 : 0);
        checkOutput("after_conflict_drop_count", drop_count, STATS ? 2 : 0);
        checkOutput("after_conflict_pulses", conflict_seen, 1);

        $display("[TB] withheld ack, then reset");
        doReset();
        ack_en = 1'b0;
        begin
            exp_t e;
            e.pbit       = 1'b1;
            e.rise_cycle = cycle + LATENCY;
            e.hist       = '0;
            e.fill       = 5'd0;
            exp_q.push_back(e);
        end
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 25);
        checkOutput("withheld_valid", press_valid, 1);
        checkOutput("withheld_bit", press_bit, 1);
        checkOutput("withheld_drop_count", drop_count, STATS ? 1 : 0);
        checkOutput("withheld_press_count", press_count, 0);
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        checkOutput("midreset_valid", press_valid, 0);
        checkOutput("midreset_bit", press_bit, 0);
        checkOutput("midreset_history", history, 0);
        checkOutput("midreset_fill", hist_fill, 0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 15);
        checkOutput("final_rises", valid_rises, 25);
        checkOutput("final_queue_empty", exp_q.size(), 0);
        checkOutput("final_no_pending", have_cur, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/press_capture.md
Name: press_capture

Overview:
- Upstream front end of the button-prediction core.
- Synchronises and debounces the two player buttons k1 and k2, and turns each accepted press into one bit: k1 = 1, k2 = 0.
- Delivers that bit to the predictor via a valid/ack handshake.
- Maintains the HIST_LEN-bit press history that the predictor consumes as its input vector.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz); minimum 2.
- HIST_LEN, 20, history length in bits; matches the predictor's weight count.
- ACTIVE_LOW, 1, 1 = buttons read 0 when pressed; 0 = buttons read 1 when pressed.

Ports:
- CLOCK_50  input  1  system clock, all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- k1  input  1  raw asynchronous button 1 (press encodes bit 1).
- k2  input  1  raw asynchronous button 2 (press encodes bit 0).
- ack  input  1  consumer has taken press_bit; valid only while press_valid = 1.
- press_valid  output  1  a captured press is pending.
- press_bit  output  1  value of the pending press.
- history  output  HIST_LEN  past presses; bit 0 = most recent acknowledged press.
- hist_fill  output  5  number of valid history bits, saturates at HIST_LEN.
- conflict  output  1  one-cycle pulse when both buttons complete a press in the same cycle.
- press_count  output  16  accepted presses (optional feature).
- drop_count  output  16  presses ignored (optional feature).

Behaviour:
- Reset (synchronous, active-high; single clock CLOCK_50):
  - Outputs: press_valid = 0, press_bit = 0, history = 0, hist_fill = 0, conflict = 0, counters = 0.
  - Internals: debounced levels = released, debounce counters = 0, FSM = IDLE.
  - Reset asserted mid-handshake discards the pending press; history is not shifted.
- Input conditioning:
  - Each button passes through a 2-FF synchroniser, then is normalised so 1 = pressed.
- Debounce, per button, independently:
  - The counter increments while the synchronised level differs from the debounced level.
  - It clears on any cycle where they match.
  - When the count reaches DEBOUNCE_CYCLES - 1 and the level still differs, the debounced level flips and the counter clears.
  - A press event is a one-cycle pulse on the debounced 0->1 transition. Releases generate no event.
- FSM states: IDLE, PENDING, HOLD.
  - IDLE, exactly one press event: press_bit <= (k1 event ? 1 : 0), press_valid <= 1 on the next edge, go to PENDING.
  - IDLE, both press events in the same cycle: no capture; conflict pulses 1 cycle; go to HOLD; drop_count += 2.
  - PENDING: press_valid and press_bit held stable until ack.
    - Any press event while in PENDING is ignored (drop_count += 1 per event).
  - PENDING, ack = 1:
    - press_valid <= 0.
    - history <= {history[HIST_LEN-2:0], press_bit}.
    - hist_fill <= min(hist_fill + 1, HIST_LEN).
    - press_count += 1.
    - Go to HOLD.
  - HOLD: wait until both debounced levels are released, then go to IDLE.
    - A button still held cannot retrigger; events in HOLD are dropped and counted.
- ack while press_valid = 0 is ignored.
- Latency: 2 synchroniser cycles + DEBOUNCE_CYCLES from a stable raw press to the debounced edge; press_valid rises one cycle after the event.
- Counters wrap modulo 2^16.
- history bits beyond hist_fill are 0.

Optional Feature:
- PRESS_CAPTURE_STATS_EN defined: press_count and drop_count are implemented as described.
- Undefined: press_count and drop_count are tied to 0 and no counter registers exist. All other behaviour is identical.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4 and ACTIVE_LOW = 1.
- Reset then idle 20 cycles -> press_valid = 0, history = 0, hist_fill = 0.
- k1 low held 10 cycles, ack on first valid cycle -> press_valid rises 7 cycles after k1 falls, press_bit = 1; after ack history = 20'h00001, hist_fill = 1.
- k2 toggling every 2 cycles for 30 cycles (bounce) -> no press_valid ever asserted.
- k1 then k2 pressed and released in turn, 22 presses total, each acked -> hist_fill saturates at 20; history equals the last 20 bits, with bit 0 = 0 for the final k2 press.
- k1 and k2 fall on the same cycle -> conflict pulses once, press_valid stays 0, drop_count = 2; after both are released a single k2 press is captured normally.
- k1 press, ack withheld 50 cycles while k2 is pressed and released -> press_bit stays 1, drop_count = 1. Assert reset with ack still low -> press_valid = 0 and history unchanged at 0.
